cr_kme_fifo_arb: RTL and testbench



---
 rtl/cr_kme_fifo_arb.sv | 145 ++++++++++++++
 tb/tb_cr_kme_fifo_arb.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_kme_fifo_arb.sv
// ---------------------------------------------------------------------------
// cr_kme_fifo_arb
//   Packet-level round-robin arbiter. It lets N_REQ KME request sources share
//   the single write port of the 128-bit KME staging FIFO. A requester that
//   wins keeps the port until its end-of-packet beat has been accepted, so
//   packets are never interleaved. A packet that reaches MAX_BEATS beats
//   without an EOT beat is cut off, and the port is arbitrated again.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   req_valid      per-requester beat valid
//   req_data       per-requester beat; requester i at [i*DATA_W +: DATA_W]
//   req_eot        per-requester last-beat flag (qualified by req_valid)
//   req_ack        beat accepted this cycle (one-hot or zero)
//   fifo_in        FIFO write data
//   fifo_in_valid  FIFO write enable
//   fifo_in_stall  FIFO has no free slot
//   grant_id       index of the current owner (meaningful while busy)
//   busy           a packet grant is held
//   pkt_done       one-cycle pulse after a packet ends (EOT or forced cut)
//   pkt_len_err    one-cycle pulse after a packet is cut at MAX_BEATS
// ---------------------------------------------------------------------------
module cr_kme_fifo_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 128,
  parameter int MAX_BEATS = 16,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_eot,
  output logic [N_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]       fifo_in,
  output logic                    fifo_in_valid,
  input  logic                    fifo_in_stall,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    pkt_done,
  output logic                    pkt_len_err
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]  grant_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             done_nxt, len_err_nxt;
  logic             beat;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  after_owner;

  // Round-robin pick: first requester at or above rr_ptr, wrapping.
  always_comb begin
    logic found;
    found  = 1'b0;
    winner = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  // The owner's successor becomes the top priority after release; handled
  // explicitly so non-power-of-two N_REQ still wraps correctly.
  assign after_owner = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant_id;
    beat_cnt_nxt  = beat_cnt;
    done_nxt      = 1'b0;
    len_err_nxt   = 1'b0;
    beat          = 1'b0;
    fifo_in_valid = 1'b0;
    req_ack       = '0;
    fifo_in       = '0;

    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt    = GRANT;
          grant_nxt    = winner;
          beat_cnt_nxt = '0;
        end
      end

      GRANT: begin
        fifo_in = req_data[int'(grant_id)*DATA_W +: DATA_W];
        // A beat moves only when the FIFO has room; gating with rst keeps the
        // abandoned packet from writing during the reset cycle itself.
        beat = req_valid[grant_id] && !fifo_in_stall && !rst;
        fifo_in_valid     = beat;
        req_ack[grant_id] = beat;

        if (beat) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (req_eot[grant_id] || (beat_cnt_nxt == CNT_W'(MAX_BEATS))) begin
            done_nxt    = 1'b1;
            len_err_nxt = !req_eot[grant_id];
            rr_ptr_nxt  = after_owner;
            state_nxt   = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      grant_id    <= '0;
      pkt_done    <= 1'b0;
      pkt_len_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      beat_cnt    <= beat_cnt_nxt;
      grant_id    <= grant_nxt;
      pkt_done    <= done_nxt;
      pkt_len_err <= len_err_nxt;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_cr_kme_fifo_arb.sv
// ---------------------------------------------------------------------------
// tb_cr_kme_fifo_arb
//   Bench for cr_kme_fifo_arb (N_REQ=4, DATA_W=128, MAX_BEATS=16). Each
//   requester is fed from its own beat queue; every beat queued also lands
//   in an expected-write queue in the order arbitration should emit it.
//   A monitor pops that queue on every FIFO write.
// ---------------------------------------------------------------------------
module tb_cr_kme_fifo_arb;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int MB = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_eot;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   fifo_in;
  logic            fifo_in_valid;
  logic            fifo_in_stall;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            pkt_done;
  logic            pkt_len_err;

  cr_kme_fifo_arb #(.N_REQ(N), .DATA_W(DW), .MAX_BEATS(MB), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_eot(req_eot),
    .req_ack(req_ack),
    .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall(fifo_in_stall),
    .grant_id(grant_id), .busy(busy),
    .pkt_done(pkt_done), .pkt_len_err(pkt_len_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic eot; } beat_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; } exp_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          len_err_cnt = 0;
  int          len_err_at = -1;
  int          wr_cyc[$];
  exp_t        sb[$];
  beat_t       src[N][$];
  logic [N-1:0] hold = '0;
  logic [N-1:0] last_ack = '0;

  // ---- stimulus helpers -----------------------------------------------------
  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src[i].size() != 0 && !hold[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = src[i][0].data;
        req_eot[i]            = src[i][0].eot;
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_eot[i]            = 1'b0;
      end
    end
  endtask

  task automatic send_pkt(input int id, input int n, input bit with_eot);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      exp_t  e;
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.eot  = with_eot && (k == n - 1);
      e.id   = IW'(id);
      e.data = b.data;
      src[id].push_back(b);
      sb.push_back(e);
    end
  endtask

  task automatic flush_sources();
    for (int i = 0; i < N; i++) src[i].delete();
    sb.delete();
    hold = '0;
  endtask

  // Outputs are sampled 1 ns after the falling edge; inputs change 1-2 ns
  // after the rising edge, so samples never straddle a transition.
  task automatic at_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [9:0] status();
    return {busy, grant_id, fifo_in_valid, req_ack, pkt_done, pkt_len_err};
  endfunction

  function automatic logic [9:0] mk(input logic b, input logic [1:0] g,
                                    input logic v, input logic [3:0] a,
                                    input logic d, input logic e);
    return {b, g, v, a, d, e};
  endfunction

  task automatic wait_writes(input int base, input int n, input int budget,
                             input string name);
    int c = 0;
    while ((wr_count - base) < n && c < budget) begin
      at_sample();
      c++;
    end
    tests++;
    if ((wr_count - base) < n) begin
      fails++;
      $display("FAIL %s: writes seen %0d, required %0d within %0d cycles",
               name, wr_count - base, n, budget);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      at_sample();
      c++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected writes still pending after %0d cycles",
               name, sb.size(), budget);
    end
  endtask

  task automatic do_reset();
    at_drive();
    rst = 1'b1;
    fifo_in_stall = 1'b0;
    flush_sources();
    drive_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // ---- requester model: retire a beat after the edge that accepted it ------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (last_ack[i] && src[i].size() != 0) void'(src[i].pop_front());
      drive_inputs();
    end
  end

  // ---- monitor / scoreboard -------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      last_ack = req_ack;
      if (pkt_len_err) begin
        len_err_cnt++;
        len_err_at = wr_count;
        tests++;
        if (pkt_done !== 1'b1) begin
          fails++;
          $display("FAIL len_err_done: pkt_done=%b with pkt_len_err, required 1", pkt_done);
        end
      end
      if (fifo_in_valid === 1'b1) begin
        tests++;
        if (fifo_in_stall) begin
          fails++;
          $display("FAIL overflow: fifo_in_valid=1 while fifo_in_stall=1");
        end else if (sb.size() == 0) begin
          fails++;
          $display("FAIL extra_write: unexpected write from grant %0d data %h", grant_id, fifo_in);
        end else begin
          exp_t         e;
          logic [N-1:0] oh;
          e  = sb.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          if (fifo_in !== e.data || grant_id !== e.id || req_ack !== oh) begin
            fails++;
            $display("FAIL write: got id %0d ack %b data %h, required id %0d ack %b data %h",
                     grant_id, req_ack, fifo_in, e.id, oh, e.data);
          end
        end
        wr_count++;
        wr_cyc.push_back(cyc);
      end else begin
        tests++;
        if (req_ack !== '0) begin
          fails++;
          $display("FAIL ack_no_write: req_ack=%b with fifo_in_valid=%b, required 0000",
                   req_ack, fifo_in_valid);
        end
      end
    end
  end

  // ---- scenarios ------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    at_sample();
    tests++;
    if (status() !== mk(0, 0, 0, 4'b0000, 0, 0)) begin
      fails++;
      $display("FAIL reset_state: status %b, required %b", status(), mk(0, 0, 0, 4'b0000, 0, 0));
    end
  endtask

  task automatic test_single_source();
    logic [9:0] exp_tab [6];
    int base;
    exp_tab[0] = mk(0, 0, 0, 4'b0000, 0, 0);  // request seen, nothing moves
    exp_tab[1] = mk(1, 0, 1, 4'b0001, 0, 0);
    exp_tab[2] = mk(1, 0, 1, 4'b0001, 0, 0);
    exp_tab[3] = mk(1, 0, 1, 4'b0001, 0, 0);
    exp_tab[4] = mk(0, 0, 0, 4'b0000, 1, 0);  // pkt_done after EOT beat
    exp_tab[5] = mk(0, 0, 0, 4'b0000, 0, 0);
    do_reset();
    base = wr_count;
    at_drive();
    send_pkt(0, 3, 1'b1);
    drive_inputs();
    for (int k = 0; k < 6; k++) begin
      at_sample();
      tests++;
      if (status() !== exp_tab[k]) begin
        fails++;
        $display("FAIL single_c%0d: status %b, required %b", k, status(), exp_tab[k]);
      end
    end
    tests++;
    if (wr_count - base != 3 || sb.size() != 0) begin
      fails++;
      $display("FAIL single_writes: %0d writes, %0d pending, required 3 and 0",
               wr_count - base, sb.size());
    end
  endtask

  task automatic test_round_robin();
    int b;
    do_reset();
    b = wr_cyc.size();
    at_drive();
    send_pkt(0, 1, 1'b1);
    send_pkt(1, 1, 1'b1);
    send_pkt(2, 1, 1'b1);
    send_pkt(3, 1, 1'b1);
    send_pkt(0, 1, 1'b1);
    drive_inputs();
    wait_drain(40, "rr_drain");
    tests++;
    if (wr_cyc.size() - b != 5) begin
      fails++;
      $display("FAIL rr_count: %0d writes, required 5", wr_cyc.size() - b);
    end else begin
      for (int k = 1; k < 5; k++) begin
        tests++;
        if (wr_cyc[b+k] - wr_cyc[b+k-1] != 2) begin
          fails++;
          $display("FAIL rr_spacing%0d: %0d cycles between writes, required 2",
                   k, wr_cyc[b+k] - wr_cyc[b+k-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int base;
    do_reset();
    base = wr_count;
    at_drive();
    send_pkt(2, 4, 1'b1);
    drive_inputs();
    wait_writes(base, 2, 20, "stall_pre");
    at_drive();
    fifo_in_stall = 1'b1;
    repeat (5) begin
      at_sample();
      tests++;
      if (status() !== mk(1, 2, 0, 4'b0000, 0, 0)) begin
        fails++;
        $display("FAIL stall_hold: status %b, required %b", status(), mk(1, 2, 0, 4'b0000, 0, 0));
      end
    end
    at_drive();
    fifo_in_stall = 1'b0;
    at_sample();
    tests++;
    if (status() !== mk(1, 2, 1, 4'b0100, 0, 0)) begin
      fails++;
      $display("FAIL stall_release: status %b, required %b", status(), mk(1, 2, 1, 4'b0100, 0, 0));
    end
    wait_drain(20, "stall_drain");
    tests++;
    if (wr_count - base != 4) begin
      fails++;
      $display("FAIL stall_count: %0d writes, required 4", wr_count - base);
    end
  endtask

  task automatic test_length_limit();
    int base;
    do_reset();
    base = wr_count;
    len_err_cnt = 0;
    len_err_at = -1;
    at_drive();
    send_pkt(1, 20, 1'b0);
    drive_inputs();
    wait_drain(80, "len_drain");
    tests++;
    if (len_err_cnt != 1 || len_err_at - base != 16) begin
      fails++;
      $display("FAIL len_err: %0d pulses after write %0d, required 1 after write 16",
               len_err_cnt, len_err_at - base);
    end
    tests++;
    if (wr_count - base != 20) begin
      fails++;
      $display("FAIL len_count: %0d writes, required 20", wr_count - base);
    end
    at_sample();
    tests++;
    if (status() !== mk(1, 1, 0, 4'b0000, 0, 0)) begin
      fails++;
      $display("FAIL len_regrant: status %b, required %b", status(), mk(1, 1, 0, 4'b0000, 0, 0));
    end
  endtask

  task automatic test_reset_mid_packet();
    int base;
    do_reset();
    at_drive();
    send_pkt(1, 1, 1'b1);  // moves rr_ptr off 0 before the abandoned packet
    drive_inputs();
    wait_drain(20, "rst_pre_drain");
    base = wr_count;
    at_drive();
    send_pkt(0, 5, 1'b1);
    drive_inputs();
    wait_writes(base, 2, 20, "rst_pre");
    at_drive();
    rst = 1'b1;
    at_sample();
    tests++;
    if (fifo_in_valid !== 1'b0 || req_ack !== '0) begin
      fails++;
      $display("FAIL rst_gate: valid %b ack %b during reset, required 0 0000", fifo_in_valid, req_ack);
    end
    at_drive();
    flush_sources();
    rst = 1'b0;
    send_pkt(0, 1, 1'b1);  // rr_ptr back at 0: req 0 before req 3
    send_pkt(3, 1, 1'b1);
    drive_inputs();
    at_sample();
    tests++;
    if (status() !== mk(0, 0, 0, 4'b0000, 0, 0)) begin
      fails++;
      $display("FAIL rst_after: status %b, required %b", status(), mk(0, 0, 0, 4'b0000, 0, 0));
    end
    wait_drain(20, "rst_drain");
    tests++;
    if (wr_count - base != 4) begin
      fails++;
      $display("FAIL rst_count: %0d writes, required 4", wr_count - base);
    end
  endtask

  task automatic test_gap();
    int base;
    do_reset();
    base = wr_count;
    at_drive();
    send_pkt(3, 5, 1'b1);
    drive_inputs();
    wait_writes(base, 1, 10, "gap_grant");
    at_drive();
    send_pkt(0, 1, 1'b1);  // competing request while req 3 owns the port
    drive_inputs();
    wait_writes(base, 2, 10, "gap_pre");
    at_drive();
    hold[3] = 1'b1;
    drive_inputs();
    repeat (3) begin
      at_sample();
      tests++;
      if (status() !== mk(1, 3, 0, 4'b0000, 0, 0)) begin
        fails++;
        $display("FAIL gap_hold: status %b, required %b", status(), mk(1, 3, 0, 4'b0000, 0, 0));
      end
    end
    at_drive();
    hold[3] = 1'b0;
    drive_inputs();
    wait_drain(30, "gap_drain");
    tests++;
    if (wr_count - base != 6) begin
      fails++;
      $display("FAIL gap_count: %0d writes, required 6", wr_count - base);
    end
  endtask

  // ---- sequence -------------------------------------------------------------
  initial begin
    rst           = 1'b1;
    fifo_in_stall = 1'b0;
    req_valid     = '0;
    req_data      = '0;
    req_eot       = '0;
    test_reset();
    test_single_source();
    test_round_robin();
    test_stall();
    test_length_limit();
    test_reset_mid_packet();
    test_gap();
    repeat (2) at_sample();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
